// File: rtl/rd_data_if.sv
// Upstream word stream plus problem-memory write port and load results for rd_data_ctr.
interface rd_data_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   num_items;
  logic              hdr_clamped;
  logic              rd_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, num_items, hdr_clamped, rd_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, num_items, hdr_clamped, rd_done
  );
endinterface

// File: rtl/rd_data_ctr.sv
// Input-load stage: takes a length header then N words, writes word k to address k,
// and pulses rd_done once so the main controller can leave RD_DATA.
module rd_data_ctr #(
  parameter int             DATA_W   = 16,
  parameter int             DEPTH    = 32,
  parameter int             ADDR_W   = 5,
  parameter logic [2:0]     STATE_RD = 3'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      current_state,
  rd_data_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] cnt;

  logic            in_rd;
  logic            acc;
  logic            hdr_over;
  logic [ADDR_W:0] n_clamp;
  logic            last;

  assign in_rd    = (current_state == STATE_RD);
  assign acc      = bus.in_valid && bus.in_ready;
  // Unsigned full-width compare; below the clamp the header fits in ADDR_W+1 bits.
  assign hdr_over = (bus.in_data > DEPTH_D);
  assign n_clamp  = hdr_over ? DEPTH_N : bus.in_data[ADDR_W:0];
  assign last     = ((cnt + 1'b1) == bus.num_items);

  // in_ready is registered, so it is set from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bus.in_ready    <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.num_items   <= '0;
      bus.hdr_clamped <= 1'b0;
      bus.rd_done     <= 1'b0;
    end else begin
      bus.wr_en   <= 1'b0;
      bus.rd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.in_ready <= 1'b0;
          if (in_rd) begin
            state        <= S_HDR;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
          end
        end

        S_HDR: begin
          if (acc) begin
            bus.num_items   <= n_clamp;
            bus.hdr_clamped <= hdr_over;
            cnt             <= '0;
            if (n_clamp == '0) begin
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              bus.rd_done  <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          // Abort wins over the header outcome but the latched header stands.
          if (!in_rd) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b0;
            bus.rd_done  <= 1'b0;
          end
        end

        S_DATA: begin
          if (acc) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cnt[ADDR_W-1:0];
            bus.wr_data <= bus.in_data;
            cnt         <= cnt + 1'b1;
            if (last) begin
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              bus.rd_done  <= 1'b1;
            end
          end
          // The write of a same-cycle handshake is kept; only completion is dropped.
          if (!in_rd) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b0;
            bus.rd_done  <= 1'b0;
          end
        end

        S_DONE: begin
          state        <= S_WAIT;
          bus.in_ready <= 1'b0;
        end

        S_WAIT: begin
          bus.in_ready <= 1'b0;
          if (!in_rd) state <= S_IDLE;
        end

        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_data_ctr.sv
// Directed bench for rd_data_ctr: load, gaps, zero length, clamp, reset and abort.
module tb_rd_data_ctr;
  localparam int         DATA_W   = 16;
  localparam int         DEPTH    = 32;
  localparam int         ADDR_W   = 5;
  localparam logic [2:0] STATE_RD = 3'd1;
  localparam logic [2:0] ST_OTHER = 3'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cs;

  int tests = 0;
  int fails = 0;

  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] wlog_addr [64];
  logic [31:0] wlog_data [64];

  rd_data_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rd_data_ctr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STATE_RD(STATE_RD)) dut (
    .clk           (clk),
    .rst           (rst),
    .current_state (cs),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Write/done log, sampled shortly after each edge once outputs have settled.
  always @(posedge clk) begin
    #2;
    if (bus.wr_en && wr_cnt < 64) begin
      wlog_addr[wr_cnt] = 32'(bus.wr_addr);
      wlog_data[wr_cnt] = 32'(bus.wr_data);
    end
    if (bus.wr_en) wr_cnt++;
    if (bus.rd_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"},    32'(bus.in_ready),    32'd0);
    chk({tag, " wr_en"},       32'(bus.wr_en),       32'd0);
    chk({tag, " wr_addr"},     32'(bus.wr_addr),     32'd0);
    chk({tag, " wr_data"},     32'(bus.wr_data),     32'd0);
    chk({tag, " num_items"},   32'(bus.num_items),   32'd0);
    chk({tag, " hdr_clamped"}, 32'(bus.hdr_clamped), 32'd0);
    chk({tag, " rd_done"},     32'(bus.rd_done),     32'd0);
  endtask

  task automatic clr();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic put(input logic v, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  initial begin
    logic [15:0] t1 [4];
    t1[0] = 16'hA0A0; t1[1] = 16'hB1B1; t1[2] = 16'hC2C2; t1[3] = 16'hD3D3;

    rst = 1'b1; cs = ST_OTHER; put(1'b0, 16'h0);
    @(negedge clk); cyc(); cyc();
    chk_zero("reset");
    rst = 1'b0;

    // 1. back-to-back load of 4 words
    clr();
    cs = STATE_RD; cyc();
    chk("t1 ready in HDR", 32'(bus.in_ready), 32'd1);
    put(1'b1, 16'd4); cyc();
    chk("t1 num_items", 32'(bus.num_items), 32'd4);
    chk("t1 hdr_clamped", 32'(bus.hdr_clamped), 32'd0);
    chk("t1 no write on header", 32'(bus.wr_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      put(1'b1, t1[i]); cyc();
      chk($sformatf("t1 wr_en %0d", i), 32'(bus.wr_en), 32'd1);
      chk($sformatf("t1 wr_addr %0d", i), 32'(bus.wr_addr), 32'(i));
      chk($sformatf("t1 wr_data %0d", i), 32'(bus.wr_data), 32'(t1[i]));
      chk($sformatf("t1 rd_done %0d", i), 32'(bus.rd_done), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t1 ready after last", 32'(bus.in_ready), 32'd0);
    put(1'b0, 16'h0); cyc();
    chk("t1 rd_done one pulse", 32'(bus.rd_done), 32'd0);
    chk("t1 wr_en after done", 32'(bus.wr_en), 32'd0);
    cs = ST_OTHER; cyc(); cyc();
    chk("t1 writes", 32'(wr_cnt), 32'd4);
    chk("t1 done count", 32'(done_cnt), 32'd1);

    // 2. gapped stream of 3 words
    clr();
    cs = STATE_RD; cyc();
    put(1'b1, 16'd3); cyc();
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < i + 1 + (i == 0 ? -1 : 0); g++) begin
        put(1'b0, 16'hDEAD); cyc();
      end
      put(1'b1, 16'(16'h0110 * (i + 1))); cyc();
    end
    put(1'b0, 16'h0); cyc(); cyc(); cyc();
    chk("t2 writes", 32'(wr_cnt), 32'd3);
    chk("t2 addr0", wlog_addr[0], 32'd0);
    chk("t2 addr1", wlog_addr[1], 32'd1);
    chk("t2 addr2", wlog_addr[2], 32'd2);
    chk("t2 data2", wlog_data[2], 32'h0330);
    chk("t2 done count", 32'(done_cnt), 32'd1);
    cs = ST_OTHER; cyc();

    // 3. zero length
    clr();
    cs = STATE_RD; cyc();
    put(1'b1, 16'd0); cyc();
    chk("t3 rd_done", 32'(bus.rd_done), 32'd1);
    chk("t3 num_items", 32'(bus.num_items), 32'd0);
    chk("t3 in_ready", 32'(bus.in_ready), 32'd0);
    put(1'b0, 16'h0); cyc();
    cs = ST_OTHER; cyc();
    chk("t3 writes", 32'(wr_cnt), 32'd0);
    chk("t3 done count", 32'(done_cnt), 32'd1);

    // 4. clamp: header 40 against 32 entries, upstream keeps offering words
    clr();
    cs = STATE_RD; cyc();
    put(1'b1, 16'd40); cyc();
    chk("t4 num_items", 32'(bus.num_items), 32'd32);
    chk("t4 hdr_clamped", 32'(bus.hdr_clamped), 32'd1);
    for (int i = 0; i < 32; i++) begin
      put(1'b1, 16'(100 + i)); cyc();
    end
    chk("t4 ready after 32nd", 32'(bus.in_ready), 32'd0);
    chk("t4 rd_done", 32'(bus.rd_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 16'(200 + i)); cyc();
    end
    chk("t4 surplus not taken", 32'(bus.in_ready), 32'd0);
    chk("t4 writes", 32'(wr_cnt), 32'd32);
    chk("t4 last addr", wlog_addr[31], 32'd31);
    chk("t4 last data", wlog_data[31], 32'd131);
    chk("t4 done count", 32'(done_cnt), 32'd1);
    put(1'b0, 16'h0); cs = ST_OTHER; cyc();

    // 5. reset after two data writes, then reload with header 2
    clr();
    cs = STATE_RD; cyc();
    put(1'b1, 16'd5); cyc();
    put(1'b1, 16'h0051); cyc();
    put(1'b1, 16'h0052); cyc();
    put(1'b0, 16'h0); rst = 1'b1; cyc();
    chk_zero("t5 reset");
    rst = 1'b0; cyc();
    put(1'b1, 16'd2); cyc();
    put(1'b1, 16'h0061); cyc();
    put(1'b1, 16'h0062); cyc();
    put(1'b0, 16'h0); cyc();
    chk("t5 writes", 32'(wr_cnt), 32'd4);
    chk("t5 addr a", wlog_addr[2], 32'd0);
    chk("t5 addr b", wlog_addr[3], 32'd1);
    chk("t5 data b", wlog_data[3], 32'h0062);
    chk("t5 num_items", 32'(bus.num_items), 32'd2);
    chk("t5 done count", 32'(done_cnt), 32'd1);
    cs = ST_OTHER; cyc();

    // 6. abort after one write; the handshake in the leaving cycle still writes
    clr();
    cs = STATE_RD; cyc();
    put(1'b1, 16'd4); cyc();
    put(1'b1, 16'h0071); cyc();
    put(1'b1, 16'h0072); cs = ST_OTHER; cyc();
    chk("t6 abort wr_en", 32'(bus.wr_en), 32'd1);
    chk("t6 abort wr_addr", 32'(bus.wr_addr), 32'd1);
    chk("t6 abort wr_data", 32'(bus.wr_data), 32'h0072);
    chk("t6 abort ready", 32'(bus.in_ready), 32'd0);
    chk("t6 abort rd_done", 32'(bus.rd_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 16'h0099); cyc();
      chk($sformatf("t6 idle wr_en %0d", i), 32'(bus.wr_en), 32'd0);
      chk($sformatf("t6 idle ready %0d", i), 32'(bus.in_ready), 32'd0);
    end
    put(1'b0, 16'h0); cyc();
    chk("t6 writes", 32'(wr_cnt), 32'd2);
    chk("t6 done count", 32'(done_cnt), 32'd0);
    chk("t6 num_items held", 32'(bus.num_items), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
